key_schedule_seq: RTL and testbench

Sequential AES-128 key-expansion unit that sits upstream of the round datapath. It loads the cipher key and iterates the key schedule one round key per clock into a 11x128 store. It then serves round keys by index, in forward order for encryption and reversed order for decryption. In decrypt mode, index 0 returns the last round key (rk10), which the decrypt-side first round consumes.

---
 rtl/aes_pkg.sv | 37 +++
 rtl/aes_subword.sv | 29 ++
 rtl/key_schedule_seq.sv | 144 ++++++++++++++
 tb/tb_key_schedule_seq.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 key-schedule constants, types and the per-round word recurrence.
// Used by key_schedule_seq and aes_subword.
package aes_pkg;

  localparam int NR   = 10;
  localparam int IDXW = 4;
  localparam logic [IDXW-1:0] NR_IDX = IDXW'(NR);

  typedef logic [127:0] rk_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } state_e;

  // Indexed directly by the round being produced (1..NR); other entries are never selected.
  localparam logic [7:0] RCON [0:15] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  // One key-schedule round: sub_rot is SubWord(RotWord(w3)) of the previous round key.
  function automatic rk_t next_round_key(input rk_t prev, input logic [31:0] sub_rot,
                                         input logic [7:0] rcon);
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] w3;
    w0 = prev[127:96] ^ sub_rot ^ {rcon, 24'h000000};
    w1 = prev[95:64]  ^ w0;
    w2 = prev[63:32]  ^ w1;
    w3 = prev[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes_subword.sv
// aes_subword: combinational forward AES SubWord on a 32-bit word (four S-box lookups).
module aes_subword (
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign word_o = {SBOX[word_i[31:24]], SBOX[word_i[23:16]],
                   SBOX[word_i[15:8]],  SBOX[word_i[7:0]]};

endmodule

// File: rtl/key_schedule_seq.sv
// key_schedule_seq: AES-128 key expansion, one round key per clock into an 11-entry store,
// served by index in forward (encrypt) or reversed (decrypt) order. Macro KEYSCHED_ZEROIZE_EN adds zeroize_i.
module key_schedule_seq
  import aes_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            key_load_i,
  input  logic [127:0]    key_i,
`ifdef KEYSCHED_ZEROIZE_EN
  input  logic            zeroize_i,
`endif
  output logic            busy_o,
  output logic            keys_ready_o,
  input  logic            rk_req_i,
  input  logic [IDXW-1:0] rk_idx_i,
  input  logic            decrypt_i,
  output logic [127:0]    rk_o,
  output logic            rk_valid_o,
  output logic            rk_err_o
);

  // Read handshake: rk_req_i is sampled on every edge with no back-pressure; each sampled
  // request produces exactly one rk_valid_o pulse on the following cycle, and rk_o holds until the next pulse.

  state_e          state_q, state_d;
  logic [IDXW-1:0] cnt_q, cnt_d;
  rk_t             work_q, work_d;
  rk_t             store_q [0:NR];
  rk_t             store_d [0:NR];
  logic            busy_q, busy_d;
  logic            ready_q, ready_d;
  rk_t             rk_q, rk_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;

  logic [31:0]     rot_w3;
  logic [31:0]     sub_rot_w3;
  rk_t             next_rk;
  logic            read_bad;
  logic [IDXW-1:0] map_idx;
  logic [IDXW-1:0] sel_idx;

  assign rot_w3 = {work_q[23:0], work_q[31:24]};

  aes_subword u_subword (
    .word_i (rot_w3),
    .word_o (sub_rot_w3)
  );

  assign next_rk = next_round_key(work_q, sub_rot_w3, RCON[cnt_q]);

  // A read coinciding with a load sees the store as not ready.
  always_comb begin
    read_bad = key_load_i || !ready_q || (rk_idx_i > NR_IDX);
    map_idx  = decrypt_i ? (NR_IDX - rk_idx_i) : rk_idx_i;
    sel_idx  = read_bad ? '0 : map_idx;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    store_d = store_q;
    busy_d  = busy_q;
    ready_d = ready_q;
    rk_d    = rk_q;
    valid_d = 1'b0;
    err_d   = err_q;

    if (key_load_i) begin
      store_d[0] = key_i;
      work_d     = key_i;
      cnt_d      = IDXW'(1);
      state_d    = EXPAND;
      busy_d     = 1'b1;
      ready_d    = 1'b0;
      err_d      = 1'b0;
    end else if (state_q == EXPAND) begin
      store_d[cnt_q] = next_rk;
      work_d         = next_rk;
      cnt_d          = cnt_q + IDXW'(1);
      if (cnt_q == NR_IDX) begin
        state_d = READY;
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
    end

    if (rk_req_i) begin
      valid_d = 1'b1;
      if (read_bad) begin
        rk_d  = '0;
        err_d = 1'b1;
      end else begin
        rk_d = store_q[sel_idx];
      end
    end

`ifdef KEYSCHED_ZEROIZE_EN
    if (zeroize_i) begin
      for (int i = 0; i <= NR; i++) store_d[i] = '0;
      work_d  = '0;
      cnt_d   = '0;
      state_d = IDLE;
      busy_d  = 1'b0;
      ready_d = 1'b0;
      rk_d    = '0;
      valid_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      for (int i = 0; i <= NR; i++) store_q[i] <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      rk_q    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      store_q <= store_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      rk_q    <= rk_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign busy_o       = busy_q;
  assign keys_ready_o = ready_q;
  assign rk_o         = rk_q;
  assign rk_valid_o   = valid_q;
  assign rk_err_o     = err_q;

endmodule

// File: tb/tb_key_schedule_seq.sv
// tb_key_schedule_seq: directed FIPS-197 vectors plus random load/read traffic against a
// word-level key-expansion model whose S-box is derived from GF(2^8) inversion.
module tb_key_schedule_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_load_i;
  logic [127:0] key_i;
  logic         busy_o;
  logic         keys_ready_o;
  logic         rk_req_i;
  logic [3:0]   rk_idx_i;
  logic         decrypt_i;
  logic [127:0] rk_o;
  logic         rk_valid_o;
  logic         rk_err_o;
`ifdef KEYSCHED_ZEROIZE_EN
  logic         zeroize_i;
`endif

  localparam logic [127:0] KEY_A   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] A_RK1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A_RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] B_RK10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  always #5 clk = ~clk;

  key_schedule_seq dut (
    .clk          (clk),
    .rst          (rst),
    .key_load_i   (key_load_i),
    .key_i        (key_i),
`ifdef KEYSCHED_ZEROIZE_EN
    .zeroize_i    (zeroize_i),
`endif
    .busy_o       (busy_o),
    .keys_ready_o (keys_ready_o),
    .rk_req_i     (rk_req_i),
    .rk_idx_i     (rk_idx_i),
    .decrypt_i    (decrypt_i),
    .rk_o         (rk_o),
    .rk_valid_o   (rk_valid_o),
    .rk_err_o     (rk_err_o)
  );

  // ---------------- reference model ----------------
  logic [7:0]   sbox [0:255];
  logic [127:0] m_keys [0:10];
  logic [127:0] exp_q [$];
  logic [127:0] m_hold;
  bit           m_busy, m_ready, m_valid, m_err;
  int           m_ticks;
  int           n_vec = 0;
  int           n_err = 0;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  // FIPS-197 word recurrence over w[0..43].
  task automatic model_load(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 11; k++) m_keys[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  task automatic model_reset();
    for (int k = 0; k < 11; k++) m_keys[k] = '0;
    exp_q.delete();
    m_hold = '0; m_busy = 0; m_ready = 0; m_valid = 0; m_err = 0; m_ticks = 0;
  endtask

  // ---------------- checking ----------------
  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outputs();
    chk1("busy_o", busy_o, m_busy);
    chk1("keys_ready_o", keys_ready_o, m_ready);
    chk1("rk_valid_o", rk_valid_o, m_valid);
    chk1("rk_err_o", rk_err_o, m_err);
    if (m_valid && exp_q.size() != 0) m_hold = exp_q.pop_front();
    chk128("rk_o", rk_o, m_hold);
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge: drive inputs, advance the model across the next rising edge, then check.
  task automatic step(input bit ld, input logic [127:0] k, input bit rq,
                      input logic [3:0] idx, input bit dec, input bit zr);
    bit           rd_bad;
    logic [127:0] rd_val;
    key_load_i = ld; key_i = k; rk_req_i = rq; rk_idx_i = idx; decrypt_i = dec;
`ifdef KEYSCHED_ZEROIZE_EN
    zeroize_i = zr;
`endif
`ifdef KEYSCHED_ZEROIZE_EN
    if (zr) begin
      for (int i = 0; i < 11; i++) m_keys[i] = '0;
      m_busy = 0; m_ready = 0; m_valid = 0; m_hold = '0;
    end else begin
`else
    begin
`endif
      rd_bad = ld || !m_ready || (idx > 4'd10);
      rd_val = rd_bad ? '0 : m_keys[dec ? 4'd10 - idx : idx];
      if (ld) begin
        model_load(k);
        m_ticks = 0; m_busy = 1; m_ready = 0; m_err = 0;
      end else if (m_busy) begin
        m_ticks++;
        if (m_ticks == 10) begin m_busy = 0; m_ready = 1; end
      end
      if (rq && rd_bad) m_err = 1;
      m_valid = rq;
      if (rq) exp_q.push_back(rd_val);
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    step(0, '0, 0, 4'd0, 0, 0);
  endtask

  task automatic rd(input logic [3:0] idx, input bit dec);
    step(0, '0, 1, idx, dec, 0);
  endtask

  task automatic load(input logic [127:0] k);
    step(1, k, 0, 4'd0, 0, 0);
  endtask

  // Returns the number of clocks until keys_ready_o is seen, or -1 past the budget.
  task automatic wait_ready(output int lat);
    lat = -1;
    for (int i = 1; i <= 14 && lat < 0; i++) begin
      idle();
      if (keys_ready_o) lat = i;
    end
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1 model_reset();
    check_outputs();
    @(negedge clk);
    check_outputs();
    rst = 1'b0;
  endtask

  // ---------------- sequence ----------------
  initial begin
    int lat;
    rst = 1'b1; key_load_i = 0; key_i = '0; rk_req_i = 0; rk_idx_i = '0; decrypt_i = 0;
`ifdef KEYSCHED_ZEROIZE_EN
    zeroize_i = 0;
`endif
    build_sbox();
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst = 1'b0;
    idle();
    chk128("reset_rk_o", rk_o, 128'h0);

    // FIPS-197 key, encrypt and decrypt reads
    load(KEY_A);
    chk1("load_busy", busy_o, 1'b1);
    wait_ready(lat);
    chk_int("ready_latency_a", lat, 10);
    rd(4'd1, 0);
    chk128("model_a_rk1", m_hold, A_RK1);
    chk128("enc_idx1", rk_o, A_RK1);
    chk1("valid_pulse", rk_valid_o, 1'b1);
    idle();
    chk1("valid_drop", rk_valid_o, 1'b0);
    chk128("rk_hold", rk_o, A_RK1);
    rd(4'd10, 0);
    chk128("model_a_rk10", m_hold, A_RK10);
    chk128("enc_idx10", rk_o, A_RK10);
    rd(4'd0, 1);
    chk128("dec_idx0", rk_o, A_RK10);
    rd(4'd10, 1);
    chk128("dec_idx10", rk_o, KEY_A);

    // out-of-range index, sticky error
    rd(4'd11, 0);
    chk128("oob_rk_o", rk_o, 128'h0);
    chk1("oob_err", rk_err_o, 1'b1);
    repeat (3) idle();
    rd(4'd2, 0);
    chk1("err_sticky", rk_err_o, 1'b1);

    // read during EXPAND, then reload at cycle 5
    load(KEY_A);
    chk1("err_clear_on_load", rk_err_o, 1'b0);
    idle();
    rd(4'd3, 0);
    chk1("expand_read_err", rk_err_o, 1'b1);
    chk128("expand_read_rk", rk_o, 128'h0);
    repeat (2) idle();
    load(KEY_B);
    wait_ready(lat);
    chk_int("ready_latency_b", lat, 10);
    rd(4'd10, 0);
    chk128("model_b_rk10", m_hold, B_RK10);
    chk128("reload_idx10", rk_o, B_RK10);

    // reset during expansion
    load(KEY_A);
    repeat (3) idle();
    async_reset();
    chk1("rst_busy", busy_o, 1'b0);
    rd(4'd0, 0);
    chk1("post_rst_err", rk_err_o, 1'b1);
    repeat (12) idle();
    chk1("post_rst_not_ready", keys_ready_o, 1'b0);
    load(KEY_B);
    wait_ready(lat);
    rd(4'd0, 1);
    chk128("post_rst_dec0", rk_o, B_RK10);

    // random traffic
    for (int n = 0; n < 800; n++) begin
      bit ld, rq;
      ld = ($urandom_range(0, 29) == 0);
      rq = !ld && ($urandom_range(0, 1) == 1);
      step(ld, {$urandom(), $urandom(), $urandom(), $urandom()}, rq,
           4'($urandom_range(0, 12)), $urandom_range(0, 1) == 1, 0);
    end

`ifdef KEYSCHED_ZEROIZE_EN
    load(KEY_A);
    wait_ready(lat);
    step(0, '0, 1, 4'd1, 0, 1);
    chk1("zeroize_ready", keys_ready_o, 1'b0);
    rd(4'd1, 0);
    chk128("zeroize_rk", rk_o, 128'h0);
    chk1("zeroize_err", rk_err_o, 1'b1);
`endif

    chk_int("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
